// File: rtl/bus_datapath_mc_if.sv
// Control-unit <-> datapath signal bundle for bus_datapath_mc.
// Strobes come from the control unit (master); the datapath (slave) returns bus, status and register views.
interface bus_datapath_mc_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    logic [NREGS-1:0] reg_out;
    logic [NREGS-1:0] reg_in;
    logic             pc_out, mdr_out, hi_out, lo_out, zhi_out, zlo_out;
    logic             pc_in, ir_in, mar_in, y_in, hi_in, lo_in, mdr_in, z_in;
    logic             inc_pc;
    logic             read;
    logic [WIDTH-1:0] mdatain;
    logic [4:0]       opcode;
    // alu_start is a request taken only while alu_busy is low and opcode is MUL/DIV;
    // alu_busy is the only back-pressure. alu_done pulses one cycle with Z already valid.
    logic             alu_start;
    logic             alu_busy;
    logic             alu_done;
    logic             div_by_zero;
    logic             bus_conflict;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] mar_q, ir_q, mdr_q;
    logic [1:0]       seq_state;

    modport master (
        output reg_out, reg_in, pc_out, mdr_out, hi_out, lo_out, zhi_out, zlo_out,
        output pc_in, ir_in, mar_in, y_in, hi_in, lo_in, mdr_in, z_in,
        output inc_pc, read, mdatain, opcode, alu_start,
        input  alu_busy, alu_done, div_by_zero, bus_conflict, bus,
        input  mar_q, ir_q, mdr_q, seq_state
    );

    modport slave (
        input  reg_out, reg_in, pc_out, mdr_out, hi_out, lo_out, zhi_out, zlo_out,
        input  pc_in, ir_in, mar_in, y_in, hi_in, lo_in, mdr_in, z_in,
        input  inc_pc, read, mdatain, opcode, alu_start,
        output alu_busy, alu_done, div_by_zero, bus_conflict, bus,
        output mar_q, ir_q, mdr_q, seq_state
    );
endinterface

// File: rtl/bus_datapath_mc.sv
// Single-bus datapath: register file, PC/IR/MAR/MDR/Y/HI/LO/Z, one-cycle ALU and an
// iterative signed MUL/DIV sequencer (magnitude shift-add / restoring divide, sign fixed at the end).
module bus_datapath_mc #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             clr,
    bus_datapath_mc_if.slave bif
);
    localparam int SH = $clog2(WIDTH);
    localparam int DW = NREGS + 6;
    localparam logic [SH-1:0] CNT_LAST = SH'(WIDTH - 1);

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} seq_state_t;

    logic [WIDTH-1:0] r_q [NREGS];
    logic [WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, zhi_q, zlo_q;
    logic [WIDTH-1:0] bus_v;
    logic [DW-1:0]    drv;

    seq_state_t       state_q, state_d;
    logic [SH-1:0]    cnt_q;
    logic             op_div_q, sign_a_q, neg_q, dz_q, done_q, dbz_q;
    logic [WIDTH-1:0] a_raw_q, m_q, acc_hi_q, acc_lo_q;

    // Later assignments win, so the list runs from lowest to highest priority.
    always_comb begin
        bus_v = '0;
        if (bif.mdr_out) bus_v = mdr_q;
        if (bif.pc_out)  bus_v = pc_q;
        if (bif.zlo_out) bus_v = zlo_q;
        if (bif.zhi_out) bus_v = zhi_q;
        if (bif.lo_out)  bus_v = lo_q;
        if (bif.hi_out)  bus_v = hi_q;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (bif.reg_out[i]) bus_v = r_q[i];
        end
    end

    assign drv = {bif.reg_out, bif.hi_out, bif.lo_out, bif.zhi_out, bif.zlo_out,
                  bif.pc_out, bif.mdr_out};
    assign bif.bus_conflict = |(drv & (drv - DW'(1)));
    assign bif.bus       = bus_v;
    assign bif.mar_q     = mar_q;
    assign bif.ir_q      = ir_q;
    assign bif.mdr_q     = mdr_q;
    assign bif.alu_busy  = (state_q != S_IDLE);
    assign bif.alu_done  = done_q;
    assign bif.div_by_zero = dbz_q;
    assign bif.seq_state = state_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (bif.reg_in[i]) r_q[i] <= bus_v;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (bif.pc_in)       pc_q <= bus_v;
            else if (bif.inc_pc) pc_q <= pc_q + WIDTH'(1);
            if (bif.ir_in)  ir_q  <= bus_v;
            if (bif.mar_in) mar_q <= bus_v;
            if (bif.y_in)   y_q   <= bus_v;
            if (bif.hi_in)  hi_q  <= bus_v;
            if (bif.lo_in)  lo_q  <= bus_v;
            if (bif.mdr_in) mdr_q <= bif.read ? bif.mdatain : bus_v;
        end
    end

    // Single-cycle ALU: A = Y, B = bus; rotates use a doubled copy of A.
    logic [SH-1:0]      shamt;
    logic [2*WIDTH-1:0] ror_w, rol_w;
    logic [WIDTH-1:0]   alu_res;

    assign shamt = bus_v[SH-1:0];
    assign ror_w = {y_q, y_q} >> shamt;
    assign rol_w = {y_q, y_q} << shamt;

    always_comb begin
        alu_res = '0;
        case (bif.opcode)
            OP_ADD:  alu_res = y_q + bus_v;
            OP_SUB:  alu_res = y_q - bus_v;
            OP_AND:  alu_res = y_q & bus_v;
            OP_OR:   alu_res = y_q | bus_v;
            OP_SHR:  alu_res = y_q >> shamt;
            OP_SHL:  alu_res = y_q << shamt;
            OP_ROR:  alu_res = ror_w[WIDTH-1:0];
            OP_ROL:  alu_res = rol_w[2*WIDTH-1:WIDTH];
            OP_NEG:  alu_res = -bus_v;
            OP_NOT:  alu_res = ~bus_v;
            default: alu_res = '0;
        endcase
    end

    logic             is_div, start_ok;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign is_div   = (bif.opcode == OP_DIV);
    assign start_ok = bif.alu_start && (state_q == S_IDLE) &&
                      ((bif.opcode == OP_MUL) || is_div);
    assign abs_a    = y_q[WIDTH-1] ? -y_q : y_q;
    assign abs_b    = bus_v[WIDTH-1] ? -bus_v : bus_v;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One iteration: MUL adds the multiplicand when the multiplier LSB is set, then shifts
    // {acc_hi,acc_lo} right; DIV shifts a dividend bit into the remainder and subtracts if it fits.
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, m_q};
        if (!div_trial[WIDTH]) begin
            div_hi_n = div_trial[WIDTH-1:0];
            div_lo_n = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_n = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
            div_lo_n = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   seq_hi, seq_lo;

    always_comb begin
        mul_prod = {acc_hi_q, acc_lo_q};
        if (neg_q) mul_prod = -mul_prod;
        seq_hi = mul_prod[2*WIDTH-1:WIDTH];
        seq_lo = mul_prod[WIDTH-1:0];
        if (op_div_q) begin
            if (dz_q) begin
                seq_hi = a_raw_q;
                seq_lo = '1;
            end else begin
                seq_hi = sign_a_q ? -acc_hi_q : acc_hi_q;
                seq_lo = neg_q ? -acc_lo_q : acc_lo_q;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            a_raw_q  <= '0;
            m_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_DONE);
            if (start_ok) begin
                cnt_q    <= '0;
                op_div_q <= is_div;
                sign_a_q <= y_q[WIDTH-1];
                neg_q    <= y_q[WIDTH-1] ^ bus_v[WIDTH-1];
                dz_q     <= (bus_v == '0);
                a_raw_q  <= y_q;
                acc_hi_q <= '0;
                acc_lo_q <= is_div ? abs_a : abs_b;
                m_q      <= is_div ? abs_b : abs_a;
                dbz_q    <= 1'b0;
            end else if (state_q == S_RUN) begin
                cnt_q    <= cnt_q + SH'(1);
                acc_hi_q <= op_div_q ? div_hi_n : mul_hi_n;
                acc_lo_q <= op_div_q ? div_lo_n : mul_lo_n;
            end else if (state_q == S_DONE) begin
                dbz_q <= op_div_q & dz_q;
            end
        end
    end

    // Z belongs to the sequencer whenever it is not idle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            zhi_q <= '0;
            zlo_q <= '0;
        end else if (state_q == S_DONE) begin
            zhi_q <= seq_hi;
            zlo_q <= seq_lo;
        end else if (bif.z_in && (state_q == S_IDLE)) begin
            zhi_q <= '0;
            zlo_q <= alu_res;
        end
    end
endmodule

// File: tb/tb_bus_datapath_mc.sv
// Self-checking bench for bus_datapath_mc: directed test-plan cases plus randomized
// bus, ALU and MUL/DIV traffic compared against an arithmetic reference model.
module tb_bus_datapath_mc;
    localparam int W  = 32;
    localparam int NR = 16;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    logic clk;
    logic clr;

    bus_datapath_mc_if #(.WIDTH(W), .NREGS(NR)) bif ();
    bus_datapath_mc #(.WIDTH(W), .NREGS(NR)) dut (.clk(clk), .clr(clr), .bif(bif));

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [W-1:0] exp_q[$];

    logic [W-1:0] m_r [NR];
    logic [W-1:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_zhi, m_zlo;
    logic         m_dbz, pend_dbz;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int s;
        s = int'(b % W);
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_SHR: return a >> s;
            OP_SHL: return a << s;
            OP_ROR: return (s == 0) ? a : ((a >> s) | (a << (W - s)));
            OP_ROL: return (s == 0) ? a : ((a << s) | (a >> (W - s)));
            OP_NEG: return 0 - b;
            OP_NOT: return ~b;
            default: return '0;
        endcase
    endfunction

    // Returns {ZHI, ZLO}.
    function automatic logic [2*W-1:0] ref_muldiv(input logic [4:0] op, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] qv, rv, pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MUL) begin
            p  = sa * sb;
            pv = p;
            return pv;
        end
        if (b == '0) return {a, {W{1'b1}}};
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[W-1:0], qv[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_r[i] = '0;
        m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0;
        m_hi = '0; m_lo = '0; m_zhi = '0; m_zlo = '0; m_dbz = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clr_strobes();
        bif.reg_out = '0; bif.reg_in = '0;
        bif.pc_out = 0; bif.mdr_out = 0; bif.hi_out = 0; bif.lo_out = 0;
        bif.zhi_out = 0; bif.zlo_out = 0;
        bif.pc_in = 0; bif.ir_in = 0; bif.mar_in = 0; bif.y_in = 0; bif.hi_in = 0;
        bif.lo_in = 0; bif.mdr_in = 0; bif.z_in = 0; bif.inc_pc = 0; bif.read = 0;
        bif.opcode = '0; bif.alu_start = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put_mdr(input logic [W-1:0] v);
        bif.read = 1; bif.mdr_in = 1; bif.mdatain = v;
        cyc(); clr_strobes();
        m_mdr = v;
    endtask

    task automatic set_reg(input int i, input logic [W-1:0] v);
        put_mdr(v);
        bif.mdr_out = 1; bif.reg_in[i] = 1'b1;
        cyc(); clr_strobes();
        m_r[i] = v;
    endtask

    task automatic set_y(input logic [W-1:0] v);
        put_mdr(v);
        bif.mdr_out = 1; bif.y_in = 1;
        cyc(); clr_strobes();
        m_y = v;
    endtask

    task automatic read_z(output logic [W-1:0] lo, output logic [W-1:0] hi);
        bif.zlo_out = 1; #1 lo = bif.bus; bif.zlo_out = 0;
        bif.zhi_out = 1; #1 hi = bif.bus; bif.zhi_out = 0;
        #1;
    endtask

    task automatic alu1(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] lo, hi;
        set_y(a);
        put_mdr(b);
        bif.mdr_out = 1; bif.opcode = op; bif.z_in = 1;
        cyc(); clr_strobes();
        m_zlo = ref_alu(op, a, b);
        m_zhi = '0;
        exp_q.push_back(m_zlo);
        exp_q.push_back(m_zhi);
        read_z(lo, hi);
        check_eq($sformatf("alu_op%0d_zlo", op), lo, exp_q.pop_front());
        check_eq($sformatf("alu_op%0d_zhi", op), hi, exp_q.pop_front());
    endtask

    // Launches with the current Y and MDR as operands (MDR drives the bus).
    task automatic fire(input logic [4:0] op);
        logic [2*W-1:0] r;
        bif.mdr_out = 1; bif.opcode = op; bif.alu_start = 1;
        cyc(); clr_strobes();
        r = ref_muldiv(op, m_y, m_mdr);
        exp_q.push_back(r[W-1:0]);
        exp_q.push_back(r[2*W-1:W]);
        pend_dbz = (op == OP_DIV) && (m_mdr == '0);
        m_dbz = 1'b0;
        check_eq("busy_after_start", bif.alu_busy, 1'b1);
        check_eq("dbz_cleared_on_start", bif.div_by_zero, m_dbz);
    endtask

    // Returns in the alu_done cycle (or after the cycle budget expires).
    task automatic finish_op(input bit poke);
        int n;
        logic [W-1:0] lo, hi, held;
        n = 0;
        while (bif.alu_done !== 1'b1 && n < 200) begin
            if (poke && n == 5) begin
                bif.mdr_out = 1; bif.opcode = OP_DIV; bif.alu_start = 1;
            end
            if (poke && n == 6) begin
                bif.mdr_out = 1; bif.opcode = OP_ADD; bif.z_in = 1;
            end
            if (poke && n == 7) begin
                bif.zlo_out = 1; #1 held = bif.bus; bif.zlo_out = 0;
                check_eq("z_held_while_busy", held, m_zlo);
            end
            cyc(); clr_strobes();
            n++;
        end
        check_eq("done_latency", n, W + 1);
        check_eq("busy_low_in_done", bif.alu_busy, 1'b0);
        m_zlo = exp_q.pop_front();
        m_zhi = exp_q.pop_front();
        m_dbz = pend_dbz;
        read_z(lo, hi);
        check_eq("seq_zlo", lo, m_zlo);
        check_eq("seq_zhi", hi, m_zhi);
        check_eq("div_by_zero", bif.div_by_zero, m_dbz);
    endtask

    task automatic after_done();
        cyc();
        check_eq("done_one_cycle", bif.alu_done, 1'b0);
        check_eq("dbz_sticky", bif.div_by_zero, m_dbz);
    endtask

    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        set_y(a);
        put_mdr(b);
        fire(op);
        finish_op(poke);
        after_done();
    endtask

    task automatic bus_random(input int iters);
        logic [NR-1:0] rm;
        logic [5:0]    mm;
        logic [W-1:0]  mv [6];
        logic [W-1:0]  ev;
        int            cnt;
        for (int it = 0; it < iters; it++) begin
            rm = NR'($urandom & $urandom & $urandom);
            mm = 6'($urandom & $urandom);
            mv[0] = m_hi; mv[1] = m_lo; mv[2] = m_zhi; mv[3] = m_zlo; mv[4] = m_pc; mv[5] = m_mdr;
            cnt = 0;
            ev  = '0;
            for (int i = 0; i < NR; i++) begin
                if (rm[i]) begin
                    if (cnt == 0) ev = m_r[i];
                    cnt++;
                end
            end
            for (int j = 0; j < 6; j++) begin
                if (mm[5-j]) begin
                    if (cnt == 0) ev = mv[j];
                    cnt++;
                end
            end
            bif.reg_out = rm;
            {bif.hi_out, bif.lo_out, bif.zhi_out, bif.zlo_out, bif.pc_out, bif.mdr_out} = mm;
            #1;
            check_eq("rand_bus", bif.bus, ev);
            check_eq("rand_conflict", bif.bus_conflict, (cnt > 1));
            clr_strobes();
        end
    endtask

    // ---------------- main sequence ----------------
    logic [4:0] op_tab [13];
    logic [W-1:0] v;
    logic seen;

    initial begin
        op_tab = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                   OP_NEG, OP_NOT, 5'b00000, 5'b11111, 5'b01011};
        bif.mdatain = '0;
        clr_strobes();
        model_reset();
        clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", bif.alu_busy, 1'b0);
        check_eq("rst_done", bif.alu_done, 1'b0);
        check_eq("rst_dbz", bif.div_by_zero, 1'b0);
        check_eq("rst_mar", bif.mar_q, '0);
        check_eq("rst_ir", bif.ir_q, '0);
        check_eq("rst_mdr", bif.mdr_q, '0);
        check_eq("rst_bus", bif.bus, '0);
        check_eq("rst_conflict", bif.bus_conflict, 1'b0);
        @(negedge clk);
        clr = 1'b1;

        // Bus transfer and conflict
        set_reg(3, 32'h0000_00A5);
        set_reg(5, 32'h5A5A_0000);
        bif.reg_out[3] = 1'b1; bif.reg_in[7] = 1'b1;
        #1 check_eq("xfer_conflict", bif.bus_conflict, 1'b0);
        cyc(); clr_strobes();
        m_r[7] = m_r[3];
        bif.reg_out[7] = 1'b1;
        #1 check_eq("r7_loaded", bif.bus, 32'h0000_00A5);
        clr_strobes();
        bif.reg_out[3] = 1'b1; bif.reg_out[5] = 1'b1;
        #1 check_eq("prio_bus", bif.bus, m_r[3]);
        check_eq("prio_conflict", bif.bus_conflict, 1'b1);
        clr_strobes();

        // Directed single-cycle ALU
        alu1(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        alu1(OP_ROL, 32'h8000_0001, 32'h0000_0004);
        alu1(OP_NEG, 32'h0000_0000, 32'h0000_0005);

        // MUL with ignored start/z_in during busy, then a back-to-back restart in the done cycle
        set_y(32'hFFFF_FFFD);
        put_mdr(32'h0000_0007);
        fire(OP_MUL);
        finish_op(1'b1);
        fire(OP_MUL);
        finish_op(1'b0);
        after_done();

        // DIV cases
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(OP_DIV, 32'h0000_0009, 32'h0000_0000, 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // PC, MDR, MAR, IR
        put_mdr(32'h0000_1234);
        bif.mdr_out = 1; bif.pc_in = 1; bif.inc_pc = 1; bif.mar_in = 1; bif.ir_in = 1;
        cyc(); clr_strobes();
        m_pc = m_mdr; m_mar = m_mdr; m_ir = m_mdr;
        bif.pc_out = 1; #1 check_eq("pc_in_over_inc", bif.bus, m_pc); clr_strobes();
        check_eq("mar_load", bif.mar_q, m_mar);
        check_eq("ir_load", bif.ir_q, m_ir);
        put_mdr(32'hFFFF_FFFF);
        bif.mdr_out = 1; bif.pc_in = 1;
        cyc(); clr_strobes();
        bif.inc_pc = 1;
        cyc(); clr_strobes();
        m_pc = m_mdr + 1;
        bif.pc_out = 1; #1 check_eq("pc_wrap", bif.bus, m_pc); clr_strobes();
        bif.inc_pc = 1;
        cyc(); clr_strobes();
        m_pc = m_pc + 1;
        bif.pc_out = 1; #1 check_eq("pc_inc", bif.bus, m_pc); clr_strobes();
        v = $urandom;
        put_mdr(v);
        check_eq("mdr_from_mem", bif.mdr_q, v);
        bif.reg_out[3] = 1'b1; bif.mdr_in = 1; bif.read = 0;
        cyc(); clr_strobes();
        m_mdr = m_r[3];
        check_eq("mdr_from_bus", bif.mdr_q, m_mdr);

        // Randomized bus traffic
        for (int i = 0; i < NR; i++) set_reg(i, $urandom);
        put_mdr($urandom);
        bif.mdr_out = 1; bif.hi_in = 1; cyc(); clr_strobes(); m_hi = m_mdr;
        put_mdr($urandom);
        bif.mdr_out = 1; bif.lo_in = 1; cyc(); clr_strobes(); m_lo = m_mdr;
        bus_random(30);

        // Randomized ALU and MUL/DIV
        for (int i = 0; i < 40; i++) begin
            alu1(op_tab[$urandom_range(0, 12)], rand_val(), rand_val());
        end
        for (int i = 0; i < 10; i++) begin
            run_op(($urandom_range(0, 1) == 1) ? OP_DIV : OP_MUL, rand_val(),
                   ($urandom_range(0, 3) == 0) ? 32'h0 : rand_val(), 1'b0);
        end

        // Reset abort in the middle of a MUL
        set_y(32'h0001_0003);
        put_mdr(32'h0000_0011);
        fire(OP_MUL);
        repeat (9) cyc();
        clr = 1'b0;
        #1;
        model_reset();
        exp_q.delete();
        check_eq("abort_busy", bif.alu_busy, 1'b0);
        check_eq("abort_done", bif.alu_done, 1'b0);
        check_eq("abort_mar", bif.mar_q, m_mar);
        check_eq("abort_mdr", bif.mdr_q, m_mdr);
        bif.zlo_out = 1; #1 check_eq("abort_zlo", bif.bus, m_zlo); clr_strobes();
        bif.reg_out[3] = 1'b1; #1 check_eq("abort_r3", bif.bus, m_r[3]); clr_strobes();
        bif.pc_out = 1; #1 check_eq("abort_pc", bif.bus, m_pc); clr_strobes();
        @(negedge clk);
        clr = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            cyc();
            if (bif.alu_done === 1'b1) seen = 1'b1;
        end
        check_eq("abort_no_done", seen, 1'b0);
        run_op(OP_MUL, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/bus_datapath_mc.md
# bus_datapath_mc

Parametrised single-bus processor datapath: NREGS general registers plus PC, IR, MAR, MDR, Y, HI, LO and a 2·WIDTH Z register, all sharing one WIDTH-bit bus. The ALU is single-cycle for logic, add and shift operations. MUL and DIV run on an iterative sequencer with a start/busy/done handshake. Bus sources are priority-resolved, and driver conflicts are flagged. The block sits under the control unit, which supplies all in/out strobes.

## Interface
- WIDTH, 32, datapath width (≥8, power of two)
- NREGS, 16, general register count (2..32)
- clk  in  1  clock, all state rising-edge
- clr  in  1  reset, asynchronous, active-low
- reg_out  in  NREGS  per-register bus drive
- reg_in  in  NREGS  per-register load from bus
- pc_out, mdr_out, hi_out, lo_out, zhi_out, zlo_out  in  1 each  bus drive
- pc_in, ir_in, mar_in, y_in, hi_in, lo_in, mdr_in, z_in  in  1 each  load strobes
- inc_pc  in  1  PC increment
- read  in  1  MDR source select: 1 = mdatain, 0 = bus
- mdatain  in  WIDTH  memory read data
- opcode  in  5  ALU operation
- alu_start  in  1  launch MUL/DIV
- alu_busy  out  1  sequencer active
- alu_done  out  1  one-cycle completion pulse
- div_by_zero  out  1  sticky until next alu_start
- bus_conflict  out  1  more than one bus driver this cycle (combinational)
- bus  out  WIDTH  current bus value
- mar_q, ir_q, mdr_q  out  WIDTH  register contents

## Operation
- Bus priority, highest first: R0..R(NREGS-1), hi, lo, zhi, zlo, pc, mdr.
  - No driver: bus = 0.
  - More than one driver: bus_conflict = 1 and the highest-priority source drives the bus.
- Register loads take the bus value at the clock edge.
- pc_in has priority over inc_pc. inc_pc alone performs PC ← PC+1, wrapping modulo 2^WIDTH.
- mdr_in loads mdatain when read=1, otherwise the bus.
- Single-cycle opcodes use A = Y and B = bus. When z_in is high, ZLO ← result and ZHI ← 0 on the edge.
  - 00011 ADD, 00100 SUB (A−B), 01001 AND, 01010 OR.
  - 00101 SHR (logical), 00110 SHL, 00111 ROR, 01000 ROL. Shift count = B[log2(WIDTH)-1:0].
  - 10000 NEG (−B), 10001 NOT (~B). Results wrap modulo 2^WIDTH.
  - Any other opcode writes 0.
- Multi-cycle opcodes launch on alu_start with opcode 01110 or 01111. Operands A = Y and B = bus are latched on the start edge.
  - MUL (01110): signed two's-complement, full 2·WIDTH product. ZHI = upper half, ZLO = lower half.
  - DIV (01111): signed, quotient truncated toward zero. ZLO = quotient, ZHI = remainder; the remainder takes the sign of the dividend.
  - DIV with B = 0: ZLO = all ones, ZHI = A, div_by_zero = 1.
  - alu_start with any other opcode is ignored.
- Sequencer FSM states:
  - IDLE → RUN on a valid alu_start.
  - RUN holds for WIDTH cycles, one iteration per cycle.
  - RUN → DONE. DONE writes Z, pulses alu_done, then returns to IDLE.
- While alu_busy=1, alu_start and z_in are ignored and Z is owned by the sequencer. All other registers and the bus remain usable.
- alu_start in the same cycle that alu_done is high is accepted; a new operation begins.

## Timing
- Reset values: every register is 0.
  - alu_busy, alu_done, div_by_zero = 0; FSM = IDLE.
  - bus_conflict and bus follow the inputs combinationally.
- clr asserted mid-operation aborts the operation. Z keeps its reset value of 0 and no alu_done is produced.
- Single-cycle ALU result lands in Z on the same edge that samples z_in.
- MUL/DIV latency: start sampled at edge k.
  - alu_busy is high from after edge k through edge k+WIDTH+1.
  - Z is written and alu_done goes high after edge k+WIDTH+1, for exactly one cycle.
  - alu_busy is low during the alu_done cycle.
- div_by_zero updates on the same edge as alu_done. It clears on the next accepted alu_start.

## Test plan
- Bus transfer and conflict: R3 = 0x0000_00A5; assert R3out+R7in → R7 = 0xA5, bus_conflict = 0. Then assert R3out and R5out together → bus = R3, bus_conflict = 1.
- ADD, ROL, NEG: Y = 0x7FFF_FFFF, bus = 1, ADD+z_in → ZLO = 0x8000_0000, ZHI = 0. ROL of 0x8000_0001 by 4 → 0x0000_0018. NEG of 5 → 0xFFFF_FFFB.
- MUL: Y = −3, bus = 7, alu_start → alu_done exactly 33 cycles after the start edge; ZHI = 0xFFFF_FFFF, ZLO = 0xFFFF_FFEB. alu_start and z_in issued during busy have no effect.
- DIV: −7 / 2 → ZLO = 0xFFFF_FFFD, ZHI = 0xFFFF_FFFF. 9 / 0 → ZLO = 0xFFFF_FFFF, ZHI = 9, div_by_zero = 1.
- PC and MDR: pc_in with inc_pc → PC = bus. PC = 0xFFFF_FFFF with inc_pc → PC = 0. mdr_in with read=1 → MDR = mdatain; with read=0 → MDR = bus.
- Reset abort: clr low at cycle 10 of a MUL → busy clears immediately, all registers are 0, and no alu_done follows; a fresh MUL afterwards completes normally.
